rr_mem_rd_arbiter: RTL and testbench

- Read-side counterpart of the per-port memory write arbiter. Arbitrates N per-port read controllers (egress/dequeue side) onto the single read port of the shared packet buffer memory.
- Uses work-conserving round-robin: idle ports are skipped.
- Tracks each issued read through a fixed-latency tag pipeline, so read data returning from memory gets a valid strobe for the port that issued it.
- Widths ADDR_W and BLOCK_BITS come from mem_pkg.

---
 rtl/mem_pkg.sv | 5 +
 rtl/rr_mem_rd_arbiter.sv | 99 +++++++++
 tb/tb_rr_mem_rd_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared packet buffer memory geometry used by the per-port read and write arbiters.
package mem_pkg;
    localparam int ADDR_W     = 12;
    localparam int BLOCK_BITS = 32;
endpackage

// File: rtl/rr_mem_rd_arbiter.sv
// Work-conserving round-robin arbiter of N port read requests onto the shared buffer read port.
// Grant and memory read enable are combinational in the request cycle; rvalid follows RD_LAT cycles later.
// Ports hold mem_re_i/mem_addr_i until granted; the tag pipeline shifts every cycle and never stalls.
module rr_mem_rd_arbiter
    import mem_pkg::*;
#(
    parameter int N      = 4,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          mem_re_i,
    input  logic [ADDR_W-1:0]     mem_addr_i [N-1:0],
    output logic [N-1:0]          mem_gnt_o,
    output logic [N-1:0]          mem_rvalid_o,
    output logic [BLOCK_BITS-1:0] mem_rdata_o,
    output logic                  mem_re_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    input  logic [BLOCK_BITS-1:0] mem_rdata_i
);

    localparam int IDX_W = (N > 2) ? $clog2(N) : 1;

    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  win;
    logic [IDX_W-1:0]  cidx;
    logic              found;
    int                cand;
    logic [RD_LAT-1:0] tag_vld;
    logic [IDX_W-1:0]  tag_idx [RD_LAT];

    // Cyclic search starting at ptr; candidate index is folded back below N
    // explicitly so non-power-of-two N never wraps into an unused index.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        cidx  = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cidx = IDX_W'(cand);
            if (rst_n && !found && mem_re_i[cidx]) begin
                found = 1'b1;
                win   = cidx;
            end
        end
    end

    always_comb begin
        mem_gnt_o  = '0;
        mem_re_o   = found;
        mem_addr_o = '0;
        if (found) begin
            mem_gnt_o[win] = 1'b1;
            mem_addr_o     = mem_addr_i[win];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (win == IDX_W'(N - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                tag_idx[s] <= '0;
            end
        end else begin
            tag_vld[0] <= found;
            tag_idx[0] <= win;
            for (int s = 1; s < RD_LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end
        end
    end

    always_comb begin
        mem_rvalid_o = '0;
        if (tag_vld[RD_LAT-1]) begin
            mem_rvalid_o[tag_idx[RD_LAT-1]] = 1'b1;
        end
    end

    assign mem_rdata_o = mem_rdata_i;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(mem_gnt_o));
    a_rv_onehot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(mem_rvalid_o));
    a_gnt_subset: assert property (@(posedge clk) disable iff (!rst_n) (mem_gnt_o & ~mem_re_i) == '0);

endmodule

// File: tb/tb_rr_mem_rd_arbiter.sv
// Bench for rr_mem_rd_arbiter: a 4-port/latency-2 and a 3-port/latency-1 instance
// checked against directed vectors and a queue-free slot-schedule reference model.
module tb_rr_mem_rd_arbiter;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]            re4, gnt4, rv4;
    logic [ADDR_W-1:0]     ad4 [3:0];
    logic                  re_o4;
    logic [ADDR_W-1:0]     addr_o4;
    logic [BLOCK_BITS-1:0] rdo4, rdi4;

    logic [2:0]            re3, gnt3, rv3;
    logic [ADDR_W-1:0]     ad3 [2:0];
    logic                  re_o3;
    logic [ADDR_W-1:0]     addr_o3;
    logic [BLOCK_BITS-1:0] rdo3, rdi3;

    rr_mem_rd_arbiter #(.N(4), .RD_LAT(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .mem_re_i(re4), .mem_addr_i(ad4),
        .mem_gnt_o(gnt4), .mem_rvalid_o(rv4), .mem_rdata_o(rdo4),
        .mem_re_o(re_o4), .mem_addr_o(addr_o4), .mem_rdata_i(rdi4));

    rr_mem_rd_arbiter #(.N(3), .RD_LAT(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .mem_re_i(re3), .mem_addr_i(ad3),
        .mem_gnt_o(gnt3), .mem_rvalid_o(rv3), .mem_rdata_o(rdo3),
        .mem_re_o(re_o3), .mem_addr_o(addr_o3), .mem_rdata_i(rdi3));

    function automatic logic [BLOCK_BITS-1:0] mdat(input logic [ADDR_W-1:0] a);
        return BLOCK_BITS'({a ^ 12'h5a5, 8'h3c, a});
    endfunction

    // Memory: returns data for the address presented RD_LAT edges earlier.
    logic [ADDR_W-1:0] ap4 [2];
    logic [ADDR_W-1:0] ap3;
    always @(posedge clk) begin
        ap4[1] <= ap4[0];
        ap4[0] <= addr_o4;
        ap3    <= addr_o3;
    end
    assign rdi4 = mdat(ap4[1]);
    assign rdi3 = mdat(ap3);

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: round-robin pointer plus a schedule of strobes indexed by due cycle.
    int                mptr [2];
    logic              sv   [2][8];
    int                sp   [2][8];
    logic [ADDR_W-1:0] sa   [2][8];

    task automatic model_step(input int u, input int n, input int lat, input logic [3:0] re,
                              input logic [4*ADDR_W-1:0] aflat, input logic [3:0] gnt,
                              input logic re_o, input logic [ADDR_W-1:0] addr_o,
                              input logic [3:0] rv, input logic [BLOCK_BITS-1:0] rdata);
        int w, p, slot;
        logic [3:0] eg, erv;
        logic [ADDR_W-1:0] ea;
        w = -1;
        if (rst_n) begin
            for (int i = 0; i < n; i++) begin
                p = (mptr[u] + i) % n;
                if (w < 0 && re[p]) w = p;
            end
        end
        eg = (w >= 0) ? 4'(1 << w) : 4'd0;
        ea = (w >= 0) ? aflat[w*ADDR_W +: ADDR_W] : '0;
        slot = cyc % 8;
        erv = (rst_n && sv[u][slot]) ? 4'(1 << sp[u][slot]) : 4'd0;
        check(u == 0 ? "m4_gnt" : "m3_gnt", gnt, eg);
        check(u == 0 ? "m4_re" : "m3_re", re_o, w >= 0);
        check(u == 0 ? "m4_addr" : "m3_addr", addr_o, ea);
        check(u == 0 ? "m4_rvalid" : "m3_rvalid", rv, erv);
        if (erv != 0) check(u == 0 ? "m4_rdata" : "m3_rdata", rdata, mdat(sa[u][slot]));
        sv[u][slot] = 1'b0;
        if (!rst_n) begin
            mptr[u] = 0;
            for (int s = 0; s < 8; s++) sv[u][s] = 1'b0;
        end else if (w >= 0) begin
            sv[u][(cyc + lat) % 8] = 1'b1;
            sp[u][(cyc + lat) % 8] = w;
            sa[u][(cyc + lat) % 8] = ea;
            mptr[u] = (w + 1) % n;
        end
    endtask

    always @(negedge clk) begin
        model_step(0, 4, 2, re4, {ad4[3], ad4[2], ad4[1], ad4[0]}, gnt4, re_o4, addr_o4, rv4, rdo4);
        model_step(1, 3, 1, {1'b0, re3}, {{ADDR_W{1'b0}}, ad3[2], ad3[1], ad3[0]},
                   {1'b0, gnt3}, re_o3, addr_o3, {1'b0, rv3}, rdo3);
        cyc++;
    end

    typedef struct {
        logic [3:0] re4; logic [3:0] g4; logic [3:0] v4;
        logic [2:0] re3; logic [2:0] g3; logic [2:0] v3;
    } vec_t;
    vec_t tv [23];

    logic [3:0] lg4;
    logic [2:0] lg3;

    initial begin
        for (int u = 0; u < 2; u++) begin
            mptr[u] = 0;
            for (int s = 0; s < 8; s++) begin
                sv[u][s] = 1'b0; sp[u][s] = 0; sa[u][s] = '0;
            end
        end
        // full contention, skip-idle 1/3, solo port 0 streaming, single request on port 2
        tv[0]  = '{4'b1111, 4'b0001, 4'b0000, 3'b111, 3'b001, 3'b000};
        tv[1]  = '{4'b1111, 4'b0010, 4'b0000, 3'b111, 3'b010, 3'b001};
        tv[2]  = '{4'b1111, 4'b0100, 4'b0001, 3'b111, 3'b100, 3'b010};
        tv[3]  = '{4'b1111, 4'b1000, 4'b0010, 3'b111, 3'b001, 3'b100};
        tv[4]  = '{4'b1111, 4'b0001, 4'b0100, 3'b000, 3'b000, 3'b001};
        tv[5]  = '{4'b1111, 4'b0010, 4'b1000, 3'b000, 3'b000, 3'b000};
        tv[6]  = '{4'b1111, 4'b0100, 4'b0001, 3'b000, 3'b000, 3'b000};
        tv[7]  = '{4'b1111, 4'b1000, 4'b0010, 3'b000, 3'b000, 3'b000};
        tv[8]  = '{4'b1010, 4'b0010, 4'b0100, 3'b000, 3'b000, 3'b000};
        tv[9]  = '{4'b1010, 4'b1000, 4'b1000, 3'b000, 3'b000, 3'b000};
        tv[10] = '{4'b1010, 4'b0010, 4'b0010, 3'b000, 3'b000, 3'b000};
        tv[11] = '{4'b1010, 4'b1000, 4'b1000, 3'b000, 3'b000, 3'b000};
        tv[12] = '{4'b0001, 4'b0001, 4'b0010, 3'b000, 3'b000, 3'b000};
        tv[13] = '{4'b0001, 4'b0001, 4'b1000, 3'b000, 3'b000, 3'b000};
        tv[14] = '{4'b0001, 4'b0001, 4'b0001, 3'b000, 3'b000, 3'b000};
        tv[15] = '{4'b0001, 4'b0001, 4'b0001, 3'b000, 3'b000, 3'b000};
        tv[16] = '{4'b0001, 4'b0001, 4'b0001, 3'b000, 3'b000, 3'b000};
        tv[17] = '{4'b0000, 4'b0000, 4'b0001, 3'b000, 3'b000, 3'b000};
        tv[18] = '{4'b0000, 4'b0000, 4'b0001, 3'b000, 3'b000, 3'b000};
        tv[19] = '{4'b0000, 4'b0000, 4'b0000, 3'b000, 3'b000, 3'b000};
        tv[20] = '{4'b0100, 4'b0100, 4'b0000, 3'b000, 3'b000, 3'b000};
        tv[21] = '{4'b0000, 4'b0000, 4'b0000, 3'b000, 3'b000, 3'b000};
        tv[22] = '{4'b0000, 4'b0000, 4'b0100, 3'b000, 3'b000, 3'b000};

        rst_n = 1'b0;
        re4 = '0;
        re3 = '0;
        for (int p = 0; p < 4; p++) ad4[p] = ADDR_W'(12'h100 + p);
        ad4[2] = 12'h010;
        for (int p = 0; p < 3; p++) ad3[p] = ADDR_W'(12'h200 + p);

        // reset hold: requests present but outputs must stay quiet
        @(posedge clk); #1;
        re4 = 4'b1111;
        re3 = 3'b111;
        @(negedge clk);
        check("rst_gnt4", gnt4, 4'b0000);
        check("rst_re4", re_o4, 1'b0);
        check("rst_addr4", addr_o4, '0);
        check("rst_rv4", rv4, 4'b0000);
        check("rst_gnt3", gnt3, 3'b000);

        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 23; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            re4 = tv[k].re4;
            re3 = tv[k].re3;
            @(negedge clk);
            check("tv_gnt4", gnt4, tv[k].g4);
            check("tv_rv4", rv4, tv[k].v4);
            check("tv_gnt3", gnt3, tv[k].g3);
            check("tv_rv3", rv3, tv[k].v3);
            if (k == 20) check("tv_addr4", addr_o4, 12'h010);
            if (k == 22) check("tv_rdata4", rdo4, mdat(12'h010));
        end

        // randomized traffic with occasional resets; ungranted requests hold their address
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            lg4 = gnt4;
            lg3 = gnt3;
            @(posedge clk); #1;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
            for (int p = 0; p < 4; p++) begin
                if (!(re4[p] && !lg4[p])) begin
                    re4[p] = ($urandom_range(0, 2) != 0);
                    ad4[p] = ADDR_W'($urandom);
                end
            end
            for (int p = 0; p < 3; p++) begin
                if (!(re3[p] && !lg3[p])) begin
                    re3[p] = ($urandom_range(0, 1) != 0);
                    ad3[p] = ADDR_W'($urandom);
                end
            end
        end

        // reset mid-flight: grant port 3, then reset before its data returns
        @(posedge clk); #1;
        rst_n = 1'b0;
        re4 = '0;
        re3 = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        re4 = 4'b1000;
        @(negedge clk);
        check("mf_gnt3", gnt4, 4'b1000);
        @(posedge clk); #1;
        rst_n = 1'b0;
        re4 = 4'b0000;
        @(negedge clk);
        check("mf_rst_rv", rv4, 4'b0000);
        check("mf_rst_gnt", gnt4, 4'b0000);
        @(posedge clk); #1;
        re4 = 4'b1100;
        @(negedge clk);
        check("mf_rst_rv2", rv4, 4'b0000);
        check("mf_rst_hold", gnt4, 4'b0000);
        check("mf_rst_re", re_o4, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mf_first_gnt", gnt4, 4'b0100);
        check("mf_no_stale", rv4, 4'b0000);
        @(posedge clk); #1;
        re4 = 4'b0000;
        repeat (4) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
